// File: rtl/andor_vector_sequencer_pkg.sv
// Shared types, constants and the golden AND/OR model for the vector sequencer.
package andor_seq_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} seq_state_t;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  // Golden gate pair: X = A & B, Y = B | C, returned as {x, y}.
  function automatic logic [1:0] andor_expect(input logic a, input logic b, input logic c);
    return {a & b, b | c};
  endfunction

endpackage

// File: rtl/andor_vector_sequencer_if.sv
// Gate-side bundle: stimulus a/b/c toward the gate pair, responses x/y back.
interface andor_vector_sequencer_if;
  logic a;
  logic b;
  logic c;
  logic x;
  logic y;

  modport master (output a, b, c, input x, y);
  modport slave  (input a, b, c, output x, y);
endinterface

// File: rtl/andor_vector_sequencer_resp_check.sv
// Combinational response checker: flags a sampled {x,y} that differs from the
// golden model for the given vector. Unknown x/y values count as mismatches.
module andor_resp_check
  import andor_seq_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             x,
  input  logic             y,
  output logic             mismatch
);

  logic [1:0] exp_xy;

  // Golden compare; case inequality so X/Z on the gate outputs is a miss.
  always_comb begin
    exp_xy   = andor_expect(vec[2], vec[1], vec[0]);
    mismatch = (x !== exp_xy[1]) || (y !== exp_xy[0]);
  end

endmodule

// File: rtl/andor_vector_sequencer.sv
// Self-timed stimulus/response sequencer around the AND/OR gate pair.
// Walks all 8 {a,b,c} vectors NUM_PASSES times; each vector is driven for
// HOLD_CYCLES cycles, x/y are captured on the edge that ends the hold window,
// and the captured pair is checked during the following SAMPLE cycle.
module andor_vector_sequencer
  import andor_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int NUM_PASSES  = 1,
  parameter int ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  andor_vector_sequencer_if.master gate,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_W-1:0]       err_count,
  output logic                   fail_vld,
  output logic [VEC_W-1:0]       fail_vec
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int PASS_W = $clog2(NUM_PASSES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VEC - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("andor_vector_sequencer: HOLD_CYCLES must be 1..255");
  end
  if (NUM_PASSES < 1 || NUM_PASSES > 255) begin : g_bad_pass
    $error("andor_vector_sequencer: NUM_PASSES must be 1..255");
  end

  seq_state_t        state_q, state_d;
  logic [VEC_W-1:0]  vec_q,   vec_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [PASS_W-1:0] pass_q,  pass_d;
  logic [VEC_W-1:0]  abc_q,   abc_d;
  logic              xs_q,    xs_d;
  logic              ys_q,    ys_d;
  logic [ERR_W-1:0]  err_q,   err_d;
  logic              fvld_q,  fvld_d;
  logic [VEC_W-1:0]  fvec_q,  fvec_d;
  logic              mismatch;

  // Checks the x/y pair captured at the end of the hold window.
  andor_resp_check u_chk (
    .vec      (vec_q),
    .x        (xs_q),
    .y        (ys_q),
    .mismatch (mismatch)
  );

  // Next-state, counters and result bookkeeping.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    pass_d  = pass_q;
    abc_d   = abc_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          pass_d  = '0;
          abc_d   = '0;
          err_d   = '0;
          fvld_d  = 1'b0;
          fvec_d  = '0;
        end
      end
      DRIVE: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          // Capture exactly HOLD_CYCLES clocks after the vector was applied.
          state_d = SAMPLE;
          xs_d    = gate.x;
          ys_d    = gate.y;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fvld_q) begin
            fvld_d = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (vec_q != VEC_LAST || pass_q != PASS_LAST) begin
          // vec wraps 7->0 naturally at the end of a pass
          state_d = DRIVE;
          vec_d   = vec_q + 1'b1;
          abc_d   = vec_q + 1'b1;
          hold_d  = '0;
          if (vec_q == VEC_LAST) pass_d = pass_q + 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      pass_q  <= '0;
      abc_q   <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
      abc_q   <= abc_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
    end
  end

  assign gate.a    = abc_q[2];
  assign gate.b    = abc_q[1];
  assign gate.c    = abc_q[0];
  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign err_count = err_q;
  assign fail_vld  = fvld_q;
  assign fail_vec  = fvec_q;

endmodule
